// File: rtl/tick_generator.sv
// tick_generator: programmable tick/rate generator with run/pause/stop control.
// Define TICK_GEN_SQUARE_EN to build the 50%-duty outclk toggle flop; otherwise outclk is tied low.
module tick_generator #(
   parameter int CNT_W = 28,
   parameter logic [CNT_W-1:0] DEFAULT_COUNT = 28'd50000000
) (
   input  logic             inclk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] finalcount,
   output logic             tick,
   output logic             outclk,
   output logic [CNT_W-1:0] count,
   output logic             running
);
   localparam logic [1:0] STOPPED = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2;
   logic [1:0] state, state_next;
   logic [CNT_W-1:0] period_reg, pending_reg, last, pend_val;
   logic pending, adv, wrap, apply, have_pend;
   always_comb begin
      last = (period_reg == '0) ? '0 : period_reg - 1'b1;
      adv = (state == RUNNING) && enable && !clear;
      // >= also catches a counter left beyond a shrunken period
      wrap = adv && (count >= last);
      have_pend = load || pending;
      pend_val = load ? finalcount : pending_reg;
      apply = have_pend && (clear || state == STOPPED || wrap);
      state_next = clear ? STOPPED : enable ? RUNNING : (state == STOPPED) ? STOPPED : PAUSED;
   end
   always_ff @(posedge inclk or posedge reset) begin
      if (reset) begin
         state <= STOPPED;
         running <= 1'b0;
         tick <= 1'b0;
         count <= '0;
         period_reg <= DEFAULT_COUNT;
         pending_reg <= '0;
         pending <= 1'b0;
      end else begin
         state <= state_next;
         running <= (state_next == RUNNING);
         tick <= wrap;
         count <= (clear || state == STOPPED || wrap) ? '0 : adv ? count + 1'b1 : count;
         pending_reg <= pend_val;
         pending <= have_pend && !apply;
         if (apply) period_reg <= pend_val;
      end
   end
`ifdef TICK_GEN_SQUARE_EN
   always_ff @(posedge inclk or posedge reset) begin
      if (reset) outclk <= 1'b0;
      else if (wrap) outclk <= ~outclk;
   end
`else
   assign outclk = 1'b0;
`endif
endmodule

// File: tb/tb_tick_generator.sv
// tb_tick_generator: randomized scoreboard bench for tick_generator against a behavioural model.
module tb_tick_generator;
   localparam int W = 8;
`ifdef TICK_GEN_SQUARE_EN
   localparam bit SQ = 1'b1;
`else
   localparam bit SQ = 1'b0;
`endif
   logic inclk = 1'b0, reset = 1'b1, enable = 1'b0, clear = 1'b0, load = 1'b0;
   logic [W-1:0] finalcount = '0;
   logic tick, outclk, running;
   logic [W-1:0] count;
   typedef struct {logic tick; logic outclk; logic running; logic [W-1:0] count;} exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0;
   int m_state, m_cnt, m_per, m_pend, m_out;
   bit m_pv;

   tick_generator #(.CNT_W(W), .DEFAULT_COUNT(8'd10)) dut (
      .inclk(inclk), .reset(reset), .enable(enable), .clear(clear), .load(load),
      .finalcount(finalcount), .tick(tick), .outclk(outclk), .count(count), .running(running));

   always #5 inclk = ~inclk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // monitor: every edge with an outstanding expectation is compared
   always @(posedge inclk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("tick", int'(tick), int'(e.tick));
         chk("outclk", int'(outclk), int'(e.outclk));
         chk("running", int'(running), int'(e.running));
         chk("count", int'(count), int'(e.count));
      end
   end

   // model: 0 stopped, 1 running, 2 paused; period 0 behaves as 1
   task automatic model(input bit en, input bit clr, input bit ld, input int f);
      int p;
      bit adv, bnd;
      exp_t x;
      p = (m_per == 0) ? 1 : m_per;
      adv = (m_state == 1) && en && !clr;
      bnd = adv && (m_cnt >= p - 1);
      if (clr || m_state == 0 || bnd) m_cnt = 0;
      else if (adv) m_cnt = m_cnt + 1;
      if (ld) begin
         m_pend = f;
         m_pv = 1'b1;
      end
      if (m_pv && (clr || m_state == 0 || bnd)) begin
         m_per = m_pend;
         m_pv = 1'b0;
      end
      if (bnd && SQ) m_out = 1 - m_out;
      m_state = clr ? 0 : en ? 1 : (m_state == 0 ? 0 : 2);
      x.tick = bnd;
      x.outclk = m_out[0];
      x.running = (m_state == 1);
      x.count = m_cnt[W-1:0];
      sb.push_back(x);
   endtask

   task automatic step(input bit en, input bit clr, input bit ld, input int f);
      @(negedge inclk);
      enable = en;
      clear = clr;
      load = ld;
      finalcount = f[W-1:0];
      model(en, clr, ld, f);
      @(posedge inclk);
   endtask

   task automatic do_reset();
      @(negedge inclk);
      #2 reset = 1'b1;
      #1;
      chk("rst_tick", int'(tick), 0);
      chk("rst_outclk", int'(outclk), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_running", int'(running), 0);
      enable = 1'b0;
      clear = 1'b0;
      load = 1'b0;
      @(negedge inclk);
      reset = 1'b0;
      m_state = 0;
      m_cnt = 0;
      m_per = 10;
      m_pend = 0;
      m_pv = 1'b0;
      m_out = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      repeat (25) step(1, 0, 0, 0);
      do_reset();
      repeat (12) step(1, 0, 0, 0);
      step(0, 1, 1, 4);
      repeat (20) step(1, 0, 0, 0);
      for (int i = 0; i < 8 && m_cnt != 1; i++) step(1, 0, 0, 0);
      step(1, 0, 1, 2);
      repeat (12) step(1, 0, 0, 0);
      step(0, 1, 1, 5);
      step(1, 0, 0, 0);
      for (int i = 0; i < 8 && m_cnt != 2; i++) step(1, 0, 0, 0);
      repeat (7) step(0, 0, 0, 0);
      repeat (8) step(1, 0, 0, 0);
      step(0, 1, 1, 0);
      repeat (6) step(1, 0, 0, 0);
      step(0, 1, 1, 1);
      repeat (6) step(1, 0, 0, 0);
      step(1, 1, 1, 7);
      repeat (10) step(1, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         step($urandom % 8 != 0, $urandom % 25 == 0, $urandom % 6 == 0, int'($urandom_range(0, 6)));
      do_reset();
      repeat (3) step(1, 0, 0, 0);
      @(negedge inclk);
      chk("drain", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tick_generator.md
Name: tick_generator

Overview:
- Programmable rate generator that sits directly upstream of the LED bounce state machine.
- Divides the 50 MHz board clock into a one-cycle `tick` enable pulse and an optional 50%-duty `outclk` square wave.
- Supports run/pause/stop control and glitch-free period changes at period boundaries.
- Replaces the bare clock divider so downstream state machines can run on `inclk` gated by `tick`, or on `outclk`.

Parameters:
- CNT_W, 28, width of the period and counter registers.
- DEFAULT_COUNT, 28'd50000000, period (in `inclk` cycles) loaded on reset.

Ports:
- inclk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous reset, active-high.
- enable  input  1  1 = run, 0 = pause.
- clear  input  1  synchronous stop: returns to STOPPED and zeroes the counter.
- load  input  1  one-cycle strobe that captures `finalcount` as the new period.
- finalcount  input  CNT_W  requested period in `inclk` cycles.
- tick  output  1  registered one-cycle pulse, once per period.
- outclk  output  1  square wave toggling on every tick (only with `TICK_GEN_SQUARE_EN`).
- count  output  CNT_W  current counter value.
- running  output  1  high while state is RUNNING.

Behaviour:
- Reset (async, any time, including mid-period):
  - state = STOPPED, count = 0, tick = 0, outclk = 0, running = 0.
  - period_reg = DEFAULT_COUNT, pending flag = 0.
- Effective period P = period_reg, except that a value of 0 is treated as 1.
- FSM states: STOPPED, RUNNING, PAUSED.
  - STOPPED -> RUNNING when enable = 1 and clear = 0.
  - RUNNING -> PAUSED when enable = 0.
  - PAUSED -> RUNNING when enable = 1.
  - Any state -> STOPPED when clear = 1; clear has highest priority.
- Counter in RUNNING:
  - if count == P-1, then count <= 0 and tick <= 1 on the next cycle;
  - otherwise count <= count+1 and tick <= 0.
- Counter in PAUSED: count is held, tick = 0, outclk is held.
- Counter in STOPPED: count = 0, tick = 0, outclk is held.
- Timing:
  - The first tick is asserted on the P-th `inclk` edge after the first RUNNING cycle.
  - After that, tick repeats every P cycles and is never wider than one cycle.
  - running is registered and equals (state == RUNNING).
- Period change (load):
  - load captures finalcount into pending_reg and sets pending.
  - While RUNNING or PAUSED, pending is applied to period_reg only at the period boundary (count == P-1 in RUNNING), so the current period always completes at the old length.
  - While STOPPED, or when clear = 1 in the same cycle, pending is applied on the next edge.
  - A load on the boundary cycle itself takes effect immediately, becoming the next period.
  - Repeated loads before a boundary: the last one wins.
- Counter overrun: if count > P-1 (P shrank while PAUSED with the immediate path disallowed), count is forced to 0 and tick fires on the next RUNNING cycle, i.e. treated as a boundary.
- count never exceeds 2^CNT_W - 1; all arithmetic is unsigned CNT_W bits.

Optional Feature:
- Macro: `TICK_GEN_SQUARE_EN`.
- Defined:
  - outclk toggles on the same edge that sets tick, giving period 2·P cycles at 50% duty.
  - outclk is held in PAUSED and STOPPED.
  - outclk is returned to 0 only by reset.
- Undefined: outclk is tied to 0 and its toggle flop is not synthesised.

Test Plan:
- Reset value check: assert reset mid-run with DEFAULT_COUNT=10 -> tick=0, outclk=0, count=0, running=0 immediately (async); after release with enable=1, first tick after 10 cycles.
- Steady-state rate: load finalcount=4 while STOPPED, then enable=1 -> tick high 1 cycle every 4 cycles; with `TICK_GEN_SQUARE_EN`, outclk period 8 cycles with 4 high / 4 low.
- Mid-period load: P=4 running, load finalcount=2 at count=1 -> that period still ends at count=3; subsequent ticks every 2 cycles.
- Pause/resume: P=5, drop enable at count=2 for 7 cycles -> count stays 2, no tick; re-enable -> tick 3 cycles later (count 2→3→4→tick).
- Degenerate period: finalcount=0 and finalcount=1 -> tick every cycle (continuous high); outclk toggles every cycle.
- Priority: clear, load=7 and enable=1 in the same cycle while RUNNING -> STOPPED, count=0, period_reg=7 on the next edge; then RUNNING with first tick 7 cycles later.
